multi_debouncer: RTL and testbench

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

---
 rtl/multi_debouncer.sv | 90 +++++++++
 tb/tb_multi_debouncer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// Per-channel 2-flop synchroniser followed by a stable-run counter debouncer.
// Define MULTI_DEBOUNCER_EDGE_EN to build the registered rise/fall pulse outputs.
module multi_debouncer #(
  parameter int   NUM_CH         = 4,
  parameter int   DEBOUNCE_COUNT = 16,
  parameter logic INIT_VAL       = 1'b0
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_sig,
  output logic [NUM_CH-1:0] out_sig,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);

  localparam int              CW       = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_COUNT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];

  // Any cycle where the synced level matches the output restarts qualification.
  always_comb begin
    sync1_d = in_sig;
    sync2_d = sync1_q;
    out_d   = out_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != out_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          out_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1_q <= {NUM_CH{INIT_VAL}};
      sync2_q <= {NUM_CH{INIT_VAL}};
      out_q   <= {NUM_CH{INIT_VAL}};
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out_sig = out_q;

`ifdef MULTI_DEBOUNCER_EDGE_EN
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;

  // Pulses are derived from the same next-state as out_q so they land in its update cycle.
  always_comb begin
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed self-checking bench for multi_debouncer (4 ch / count 16, plus a 2 ch / count 1 instance).
// Pulse expectations follow whichever build MULTI_DEBOUNCER_EDGE_EN selects.
`timescale 1ns/1ps
module tb_multi_debouncer;

`ifdef MULTI_DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b0;
  logic [3:0] in_sig  = 4'b0000;
  logic [3:0] out_sig, rise, fall;
  logic [1:0] in1     = 2'b11;
  logic [1:0] out1, rise1, fall1;

  int tests_run    = 0;
  int tests_failed = 0;

  multi_debouncer #(.NUM_CH(4), .DEBOUNCE_COUNT(16), .INIT_VAL(1'b0)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .in_sig  (in_sig),
    .out_sig (out_sig),
    .rise    (rise),
    .fall    (fall)
  );

  multi_debouncer #(.NUM_CH(2), .DEBOUNCE_COUNT(1), .INIT_VAL(1'b1)) dut1 (
    .sys_clk (sys_clk),
    .rst     (rst),
    .in_sig  (in1),
    .out_sig (out1),
    .rise    (rise1),
    .fall    (fall1)
  );

  // 12 MHz
  always #41.667 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [3:0] e_out,
                          input logic [3:0] e_rise, input logic [3:0] e_fall);
    chk({tag, ".out"}, out_sig, e_out);
    chk({tag, ".rise"}, rise, EDGE_EN ? e_rise : 4'b0000);
    chk({tag, ".fall"}, fall, EDGE_EN ? e_fall : 4'b0000);
  endtask

  initial begin
    logic [3:0] eo;
    @(negedge sys_clk);

    // reset pulse
    rst = 1'b1; in_sig = 4'b0000; in1 = 2'b11;
    tick();
    rst = 1'b0;
    chk_main("reset", 4'b0000, 4'b0000, 4'b0000);
    chk("reset.out1", {2'b00, out1}, 4'b0011);

    // count=1 instance: ch1 falls on edge 3
    in1 = 2'b01;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("dc1.out1.e%0d", e), {2'b00, out1}, (e >= 3) ? 4'b0001 : 4'b0011);
      chk($sformatf("dc1.fall1.e%0d", e), {2'b00, fall1},
          (EDGE_EN && e == 3) ? 4'b0010 : 4'b0000);
      chk($sformatf("dc1.rise1.e%0d", e), {2'b00, rise1}, 4'b0000);
    end

    // clean rise on ch0: out at edge 18
    in_sig = 4'b0001;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk_main($sformatf("clean.e%0d", e), (e >= 18) ? 4'b0001 : 4'b0000,
               (e == 18) ? 4'b0001 : 4'b0000, 4'b0000);
    end

    // bounce on ch1: high 15, low 3, then held high -> qualifies at edge 36
    for (int e = 1; e <= 38; e++) begin
      in_sig[1] = (e <= 15 || e >= 19);
      tick();
      eo = (e >= 36) ? 4'b0011 : 4'b0001;
      chk_main($sformatf("bounce.e%0d", e), eo,
               (e == 36) ? 4'b0010 : 4'b0000, 4'b0000);
    end

    // bring ch3 high
    in_sig[3] = 1'b1;
    for (int e = 1; e <= 18; e++) tick();
    chk_main("ch3up.e18", 4'b1011, 4'b1000, 4'b0000);

    // simultaneous ch2 rise / ch3 fall
    in_sig[2] = 1'b1; in_sig[3] = 1'b0;
    for (int e = 1; e <= 17; e++) tick();
    chk_main("simul.e17", 4'b1011, 4'b0000, 4'b0000);
    tick();
    chk_main("simul.e18", 4'b0111, 4'b0100, 4'b1000);
    tick();
    chk_main("simul.e19", 4'b0111, 4'b0000, 4'b0000);

    // clear everything, then reset ch0 mid-qualification at cnt=10
    in_sig = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_main("reset2", 4'b0000, 4'b0000, 4'b0000);
    in_sig = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk_main($sformatf("pre_rst.e%0d", e), 4'b0000, 4'b0000, 4'b0000);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_main("mid_rst", 4'b0000, 4'b0000, 4'b0000);
    for (int r = 1; r <= 19; r++) begin
      tick();
      chk_main($sformatf("post_rst.r%0d", r), (r >= 18) ? 4'b0001 : 4'b0000,
               (r == 18) ? 4'b0001 : 4'b0000, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
